// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side signals of the
// four-way UART transmit arbiter, plus status and a debug view of the FSM state.
//
// Handshake: a transfer happens on a rising clk edge where the producer's
// valid and the consumer's ready are both 1. The requester byte i is taken
// on an edge with req_valid[i]=1 and req_ready[i]=1. The byte on tx_data is
// taken by the UART on an edge with tx_valid=1 and tx_ready=1. Once asserted,
// tx_valid stays high with tx_data unchanged until that edge.
interface uart_tx_arbiter_if;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        busy;
   logic [1:0]  last_grant;
   logic        tx_timeout;
   logic [7:0]  timeout_count;
   logic [1:0]  state;        // debug: 0=IDLE, 1=SEND, 2=GAP

   modport master (
      output req_valid, req_data, tx_ready,
      input  req_ready, tx_valid, tx_data, busy, last_grant,
             tx_timeout, timeout_count, state
   );

   modport slave (
      input  req_valid, req_data, tx_ready,
      output req_ready, tx_valid, tx_data, busy, last_grant,
             tx_timeout, timeout_count, state
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds bytes from four requesters
// to one UART transmitter, with an idle gap of GAP_CYCLES after every byte.
// Optional feature macro: UART_TX_TIMEOUT_EN abandons a byte that the UART
// has not taken within TIMEOUT_CYCLES cycles of SEND.
module uart_tx_arbiter #(
   parameter int          GAP_CYCLES     = 2,
   parameter logic [29:0] TIMEOUT_CYCLES = 30'd50000000
) (
   input logic              clk,
   input logic              reset,
   uart_tx_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Counter wide enough to hold GAP_CYCLES-1.
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t        state;
   state_t        state_nx;
   logic [1:0]    rr_ptr;
   logic [1:0]    winner;
   logic [1:0]    idx;
   logic          any_req;
   logic [GW-1:0] gap_cnt;
   logic [1:0]    last_grant_q;
   logic [7:0]    tx_data_q;
   logic [3:0]    req_ready_c;
   logic          tx_valid_c;
   logic          abandon;
   logic          done;

   // Winner search: first set request at or above rr_ptr, wrapping 3->0.
   // Scanning offsets downward lets the smallest offset overwrite last.
   always_comb begin
      winner  = rr_ptr;
      idx     = rr_ptr;
      any_req = |bus.req_valid;
      for (int k = 3; k >= 0; k--) begin
         idx = rr_ptr + 2'(k);
         if (bus.req_valid[idx]) winner = idx;
      end
   end

   // SEND ends on a UART transfer or, when enabled, on an abandon.
   assign done = (state == SEND) && (bus.tx_ready || abandon);

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_nx    = state;
      req_ready_c = 4'b0000;
      tx_valid_c  = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               req_ready_c[winner] = 1'b1;
               state_nx            = SEND;
            end
         end
         SEND: begin
            tx_valid_c = 1'b1;
            if (done) state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
         end
         GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Byte latch, grant record, round-robin pointer and gap counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data_q    <= 8'd0;
         last_grant_q <= 2'd0;
         rr_ptr       <= 2'd0;
         gap_cnt      <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            tx_data_q    <= bus.req_data[{winner, 3'b000} +: 8];
            last_grant_q <= winner;
         end
         if (done) rr_ptr <= last_grant_q + 2'd1;
         // Held at zero outside GAP, so it is clear on every GAP entry.
         if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
         else              gap_cnt <= '0;
      end
   end

`ifdef UART_TX_TIMEOUT_EN
   logic [29:0] to_cnt;
   logic        to_pulse;
   logic [7:0]  to_count;

   // Abandon at the end of the TIMEOUT_CYCLES-th SEND cycle without tx_ready.
   assign abandon = (state == SEND) && !bus.tx_ready &&
                    (to_cnt == TIMEOUT_CYCLES - 30'd1);

   // SEND cycle counter, timeout pulse and saturating abandon count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt   <= 30'd0;
         to_pulse <= 1'b0;
         to_count <= 8'd0;
      end else begin
         to_pulse <= abandon;
         if (abandon && to_count != 8'hFF) to_count <= to_count + 8'd1;
         if (state == SEND) to_cnt <= to_cnt + 30'd1;
         else               to_cnt <= 30'd0;
      end
   end

   assign bus.tx_timeout    = to_pulse;
   assign bus.timeout_count = to_count;
`else
   // SEND waits indefinitely; TIMEOUT_CYCLES has no effect in this build.
   if (TIMEOUT_CYCLES == 30'd0) begin : g_timeout_unused
   end
   assign abandon           = 1'b0;
   assign bus.tx_timeout    = 1'b0;
   assign bus.timeout_count = 8'd0;
`endif

   assign bus.req_ready  = req_ready_c;
   assign bus.tx_valid   = tx_valid_c;
   assign bus.tx_data    = tx_data_q;
   assign bus.busy       = (state != IDLE);
   assign bus.last_grant = last_grant_q;
   assign bus.state      = state;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have the following parameter: GAP_CYCLES, default 2, minimum idle cycles between consecutive bytes (0 allowed).
REQ-002 The block SHALL have the following parameter: TIMEOUT_CYCLES, default 30'd50000000, maximum cycles to wait for tx_ready; used only under UART_TX_TIMEOUT_EN.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  4  per-requester byte-pending flag; bit i belongs to requester i.
REQ-006 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 req_ready  output  4  one-hot accept; req_ready[i]=1 marks the cycle in which requester i's byte is taken.
REQ-008 tx_ready  input  1  UART transmitter can take a byte.
REQ-009 tx_valid  output  1  byte on tx_data is offered to the UART.
REQ-010 tx_data  output  8  byte offered to the UART.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 last_grant  output  2  index of the most recently accepted requester.
REQ-013 tx_timeout  output  1  one-cycle pulse when a byte is abandoned.
REQ-014 timeout_count  output  8  saturating count of abandoned bytes.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-016 Handshake rule: a byte is transferred to the UART on a rising edge where tx_valid=1 and tx_ready=1; a requester byte is accepted on a rising edge where req_valid[i]=1 and req_ready[i]=1.
REQ-017 Behaviour in IDLE with any req_valid bit set:
- Winner = first set bit searching upward from rr_ptr, wrapping 3->0.
- req_ready[winner]=1 combinationally in that same cycle.
- On the edge: tx_data <= winner byte, last_grant <= winner, state -> SEND.
REQ-018 req_ready SHALL be 0 in every state other than IDLE, and SHALL have at most one bit set in any cycle.
REQ-019 In SEND, tx_valid SHALL be 1 and tx_data SHALL hold the latched byte unchanged until the transfer completes; req_valid and req_data are ignored in SEND.
REQ-020 On transfer completion:
- rr_ptr <= (last_grant+1) mod 4.
- state -> GAP if GAP_CYCLES>0, otherwise IDLE.
REQ-021 GAP SHALL:
- Hold tx_valid=0.
- Count GAP_CYCLES cycles with a counter cleared on entry.
- Return to IDLE.
REQ-022 Accept latency: the first tx_valid=1 cycle SHALL be the cycle immediately after acceptance.
REQ-023 Minimum spacing: accepts SHALL be at least GAP_CYCLES+2 cycles apart.
REQ-024 A requester dropping req_valid after acceptance SHALL NOT affect the byte in flight.
REQ-025 When all req_valid bits are 0 in IDLE, the block SHALL stay in IDLE with all outputs at their idle values.
REQ-026 When tx_ready is already 1 on SEND entry, the transfer SHALL complete in one SEND cycle.

Reset
REQ-027 While reset=1, the block SHALL hold the following values, applied asynchronously:
- state=IDLE, rr_ptr=0, gap counter=0, timeout counter=0.
- tx_valid=0, tx_data=8'd0, req_ready=4'b0000.
- busy=0, last_grant=0, tx_timeout=0, timeout_count=0.
REQ-028 Reset asserted during SEND SHALL drop tx_valid immediately and discard the in-flight byte; after release, no byte SHALL be re-offered.
REQ-029 The first cycle after reset release SHALL behave as IDLE with rr_ptr=0.

Configuration
REQ-030 With UART_TX_TIMEOUT_EN defined, the block SHALL count cycles in SEND and abandon a byte not completed after TIMEOUT_CYCLES cycles; on that edge it SHALL:
- Pulse tx_timeout for one cycle.
- Increment timeout_count, saturating at 255.
- Advance rr_ptr as on a completed transfer.
- Enter GAP, or IDLE if GAP_CYCLES=0.
REQ-031 With UART_TX_TIMEOUT_EN undefined, SEND SHALL wait indefinitely, tx_timeout SHALL be constant 0, timeout_count SHALL be constant 0, and no timeout counter SHALL be synthesized.

Verification
REQ-032 Single requester: req_valid=4'b0100, req_data[23:16]=8'd68, tx_ready=1 -> req_ready=4'b0100 for one cycle; next cycle tx_valid=1 with tx_data=68 for one cycle; last_grant=2; 2 GAP cycles follow.
REQ-033 Round robin: all four req_valid held at 1, tx_ready=1, GAP_CYCLES=2 -> grant order 0,1,2,3,0; accepts exactly 4 cycles apart.
REQ-034 Backpressure: tx_ready=0 for 10 cycles after acceptance of 8'd82 -> tx_valid=1 and tx_data=82 stable for 10 cycles; completion on the first tx_ready=1 edge; busy=1 throughout.
REQ-035 Reset mid-operation: reset asserted in the 3rd SEND cycle -> tx_valid=0 in the same cycle; after release no byte is transferred until a new req_valid; the next grant goes to the lowest set index from 0.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=16, tx_ready=0) -> one tx_timeout pulse 16 cycles after SEND entry; timeout_count=1; the next requester is served afterwards.
REQ-037 Timeout (macro off, same stimulus) -> no tx_timeout pulse; tx_valid remains 1 indefinitely.
